// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//
// Receives frames of the form start(0), DATA_WIDTH data bits LSB first,
// optional parity, stop(1) on RX_IN. Each bit lasts PRESCALE clock cycles.
// The bit value is the majority of three samples taken around mid-bit.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous, active-high reset
//   RX_IN      asynchronous serial line, idles high
//   PRESCALE   clock cycles per bit (8, 16 or 32), latched at start detect
//   PAR_EN     1 = parity bit present, latched at start detect
//   PAR_TYP    0 = even, 1 = odd, latched at start detect
//   P_DATA     last good received byte
//   DATA_VALID one-cycle strobe: P_DATA has just been updated
//   PAR_ERR    one-cycle strobe: received parity bit was wrong
//   STP_ERR    one-cycle strobe: stop bit sampled as 0
//
// Handshake: the outputs are strobes with no backpressure. DATA_VALID is
// high for exactly one cycle per good frame and P_DATA stays stable until
// the next good frame. PAR_ERR and STP_ERR may pulse together; on either
// error DATA_VALID stays low and P_DATA keeps its previous value.

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] CNT_TWO  = PRESCALE_W'(2);
  localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Synchroniser (sync1, sync2) and previous-value flop for edge detect.
  logic sync1_q, sync2_q, prev_q;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [1:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  logic [PRESCALE_W-1:0] half;
  logic start_det, bit_end, take0, take1, decide, maj;

  assign half      = prescale_q >> 1;
  assign start_det = ~sync2_q & prev_q;
  assign bit_end   = (edge_cnt_q == prescale_q - CNT_ONE);

  // Samples are captured on the edges that advance the counter to P/2-1 and
  // P/2. The third sample (counter advancing to P/2+1) is the live synced
  // value, so the bit decision and any registered output land on that same
  // edge rather than one cycle later.
  assign take0  = (edge_cnt_q == half - CNT_TWO);
  assign take1  = (edge_cnt_q == half - CNT_ONE);
  assign decide = (edge_cnt_q == half);
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) |
                  (samp_q[1] & sync2_q);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + CNT_ONE;
      if (take0) samp_d[0] = sync2_q;
      if (take1) samp_d[1] = sync2_q;
    end

    case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d    = START;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_bad_d  = 1'b0;
        end
      end
      START: begin
        // A start bit that votes high was noise on the line.
        if (decide && maj) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      PARITY: begin
        if (decide) par_bad_d = (maj != ((^shift_q) ^ par_typ_q));
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Leave at mid stop bit so a following start edge is not missed.
        if (decide) begin
          if (maj && !par_bad_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          stp_err_d  = ~maj;
          par_err_d  = par_bad_q;
          state_d    = IDLE;
          edge_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      samp_q       <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      sync1_q      <= RX_IN;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx.
// A serialiser task drives frames; a monitor logs every output strobe with
// its cycle number; the scoreboard compares the log against expected
// {flags, P_DATA, cycle} records built from hand-computed latencies.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int EW = 43; // {dv, par_err, stp_err, data[7:0], cycle[31:0]}

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] ev_q[$];

  typedef struct {
    int         p;
    logic       pe;
    logic       pt;
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic [2:0] flags;    // {DATA_VALID, PAR_ERR, STP_ERR}
    logic [7:0] exp_data; // P_DATA during and after the strobe
    int         lat;      // edge of the strobe relative to edge 0
  } vec_t;

  vec_t vecs[11];

  // ---------------- clock / reset / DUT ----------------
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  // Monitor: one record per cycle in which any strobe is high, so a strobe
  // lasting two cycles shows up as an extra record.
  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1 || PAR_ERR === 1'b1 || STP_ERR === 1'b1)
      ev_q.push_back({DATA_VALID, PAR_ERR, STP_ERR, P_DATA, 32'(cyc)});
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_events(input string name);
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (ev_q.size() == 0) begin
        check({name, " strobe present"}, 64'd0, 64'd1);
      end else begin
        o = ev_q.pop_front();
        check({name, " strobe {flags,data,cycle}"}, 64'(o), 64'(e));
      end
    end
    check({name, " no extra strobes"}, 64'(ev_q.size()), 64'd0);
    ev_q.delete();
  endtask

  task automatic expect_ev(input logic [2:0] flags, input logic [7:0] d,
                           input int at);
    exp_q.push_back({flags, d, 32'(at)});
  endtask

  // ---------------- driver ----------------
  // Starts at a negedge: the next posedge is edge 0 of the frame. The
  // configuration inputs are changed right after the latch edge to show they
  // are held for the whole frame.
  task automatic send_frame(input int p, input logic pe, input logic pt,
                            input logic [7:0] d, input logic pbit,
                            input logic stop, input int stop_len);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    RX_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    PRESCALE = (p == 8) ? 6'd16 : 6'd8;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    repeat (p - 3) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge CLK);
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stop;
    repeat (stop_len) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- test ----------------
  initial begin
    int t0;

    //           p  pe    pt    d      pbit  stop  flags   exp_data lat
    vecs[0]  = '{8,  1'b1, 1'b0, 8'hA9, 1'b0, 1'b1, 3'b100, 8'hA9,  87};
    vecs[1]  = '{8,  1'b1, 1'b1, 8'hAB, 1'b1, 1'b1, 3'b010, 8'hA9,  87};
    vecs[2]  = '{16, 1'b0, 1'b0, 8'hE9, 1'b0, 1'b1, 3'b100, 8'hE9, 155};
    vecs[3]  = '{8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 3'b001, 8'hE9,  79};
    vecs[4]  = '{8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 3'b011, 8'hE9,  87};
    vecs[5]  = '{32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'b100, 8'h00, 339};
    vecs[6]  = '{32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 3'b100, 8'hFF, 307};
    vecs[7]  = '{16, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 3'b100, 8'hA5, 171};
    vecs[8]  = '{8,  1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'b100, 8'hFF,  87};
    vecs[9]  = '{16, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 3'b100, 8'hA5, 171};
    vecs[10] = '{8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'b100, 8'h00,  79};

    RST      = 1'b1;
    RX_IN    = 1'b1;
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    check("reset P_DATA", 64'(P_DATA), 64'h0);
    check("reset DATA_VALID", 64'(DATA_VALID), 64'd0);
    check("reset PAR_ERR", 64'(PAR_ERR), 64'd0);
    check("reset STP_ERR", 64'(STP_ERR), 64'd0);
    idle(4);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      t0 = cyc + 1;
      expect_ev(vecs[i].flags, vecs[i].exp_data, t0 + vecs[i].lat);
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d,
                 vecs[i].pbit, vecs[i].stop, vecs[i].p);
      idle(20);
      check_events($sformatf("vec%0d", i));
      check($sformatf("vec%0d P_DATA after", i), 64'(P_DATA),
            64'(vecs[i].exp_data));
    end

    // Back-to-back frames at P=16 without parity.
    t0 = cyc + 1;
    expect_ev(3'b100, 8'hE9, t0 + 155);
    expect_ev(3'b100, 8'h3C, t0 + 160 + 155);
    send_frame(16, 1'b0, 1'b0, 8'hE9, 1'b0, 1'b1, 16);
    send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 16);
    idle(20);
    check_events("back_to_back");
    check("back_to_back P_DATA", 64'(P_DATA), 64'h3C);

    // Stop bit cut to P-2 so the next start edge is detected in the very
    // cycle the receiver is back in IDLE.
    t0 = cyc + 1;
    expect_ev(3'b100, 8'h96, t0 + 87);
    expect_ev(3'b100, 8'h69, t0 + 86 + 87);
    send_frame(8, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1, 6);
    send_frame(8, 1'b1, 1'b0, 8'h69, 1'b0, 1'b1, 8);
    idle(20);
    check_events("restart_on_idle");

    // Stop error with the line then held low: no retrigger.
    t0 = cyc + 1;
    expect_ev(3'b001, 8'h69, t0 + 79);
    send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8);
    RX_IN = 1'b0;
    repeat (40) @(negedge CLK);
    check_events("stop_err_held_low");
    idle(16);

    // Two-cycle glitch: rejected, then a clean frame proves IDLE.
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) @(negedge CLK);
    idle(40);
    check_events("glitch");
    t0 = cyc + 1;
    expect_ev(3'b100, 8'hC3, t0 + 79);
    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8);
    idle(20);
    check_events("after_glitch");

    // Reset in the middle of the data bits of a 0x55 frame.
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RX_IN = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (8) @(negedge CLK);
    end
    RST   = 1'b1;
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(100);
    check_events("reset_mid_frame");
    check("reset_mid_frame P_DATA", 64'(P_DATA), 64'h0);
    t0 = cyc + 1;
    expect_ev(3'b100, 8'h81, t0 + 79);
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 8);
    idle(20);
    check_events("after_reset");
    check("after_reset P_DATA", 64'(P_DATA), 64'h81);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Sits directly downstream of the UART transmitter and consumes its serial line.
- Oversamples RX_IN by a runtime PRESCALE and takes a 3-sample majority vote per bit.
- Deserialises the frame LSB first, checks optional parity and the stop bit, and presents a byte with a one-cycle valid pulse.
- Frame format: start(0), 8 data bits LSB first, optional parity, stop(1).

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of PRESCALE input

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset; synchronous, active-high
RX_IN  input  1  asynchronous serial line, idle high
PRESCALE  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last good received byte
DATA_VALID  output  1  one-cycle pulse, P_DATA updated
PAR_ERR  output  1  one-cycle pulse, parity mismatch
STP_ERR  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset and clock: one clock; RST is synchronous and active-high.
- Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. FSM=IDLE, counters=0. Synchroniser and edge-detect flops are set to 1.
- RST mid-frame: the frame is abandoned, with no outputs for it.
- Input synchronisation: RX_IN passes through a 2-flop synchroniser. A third flop holds the previous synced value.
- Start detect: synced value 0 while previous value is 1, a falling edge only. A line held low never retriggers.
- PRESCALE, PAR_EN and PAR_TYP are latched at start detect and held for the whole frame.
- Edge counter: runs 0..P-1 per bit, P = latched PRESCALE. A bit counter tracks the current bit index.
- Sampling: synced line is sampled at edge counts P/2-1, P/2 and P/2+1. Bit value = majority of the 3 samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on start detect, with edge counter=0.
- START: if the majority is 1, the start was a glitch; go to IDLE with no outputs. Otherwise go to DATA when the edge counter reaches P-1.
- DATA: 8 bits shifted LSB first. After bit 7, go to PARITY if PAR_EN, else to STOP.
- PARITY: expected bit = XOR(data) XOR PAR_TYP. A mismatch is recorded. Go to STOP at edge P-1.
- STOP: on the third stop sample (edge P/2+1), act on the outcome and go straight to IDLE. This early exit allows back-to-back frames.
- Stop outcome, good frame (stop=1, no parity error): P_DATA <= data and DATA_VALID=1 for exactly one cycle.
- Stop outcome, stop=0: STP_ERR pulses.
- Stop outcome, parity error: PAR_ERR pulses.
- Both errors may pulse in the same cycle.
- On any error, DATA_VALID stays 0 and P_DATA holds its previous value.
- Latency: count the CLK edge that first captures RX_IN=0 as edge 0. Outputs are high during the cycle after edge (F-1)*P + P/2 + 3, where F = 11 with parity and 10 without.
- Worked values for P=8: 87 with parity, 79 without.
- Boundary: a start edge arriving in the cycle the FSM returns to IDLE is accepted.
- Boundary: no output ever asserts for more than one cycle.
- Boundary: PRESCALE values other than 8/16/32 are unsupported; behaviour is undefined.

Test Plan:
- Even parity: P=8, PAR_EN=1, PAR_TYP=0, frame for 0xA9 with parity bit 0 -> DATA_VALID one-cycle pulse at edge 87, P_DATA=0xA9, PAR_ERR=STP_ERR=0.
- Odd parity error: P=8, PAR_TYP=1, frame for 0xAB with corrupted parity bit 1 (correct is 0) -> PAR_ERR one pulse, DATA_VALID=0, P_DATA stays 0xA9.
- No parity: P=16, PAR_EN=0, frame for 0xE9, then a second frame for 0x3C starting immediately after the stop bit -> two DATA_VALID pulses, P_DATA=0xE9 then 0x3C, no errors.
- Stop error and glitch: stop bit driven 0 -> STP_ERR pulse only, and no restart while the line stays low. Separately, RX_IN low for 2 cycles at P=8 -> no output pulses, FSM back in IDLE.
- Reset: RST=1 asserted mid-DATA of a 0x55 frame, then a clean 0x81 frame -> no output for 0x55, and 0x81 received correctly.
- Loopback: uart_tx TX_OUT driven at one bit per P cycles into uart_rx for 0x00, 0xFF and 0xA5 in all parity modes -> every byte received intact.
